ysyx_25050148_mem_arbiter: RTL and testbench
============================================

# ysyx_25050148_mem_arbiter

Two-requester arbiter sharing the single physical-memory port (the DPI-backed load/store memory) between instruction fetch (IFU) and load/store unit (LSU) of the multi-cycle core. Accepts one request at a time, forwards it on a valid/ready request channel, waits for the response and returns it to the owner. Round-robin arbitration prevents starvation; exactly one transaction is outstanding at any time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid (one-cycle pulse)
- ifu_rdata  out  DATA_W  fetch data
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  4  store byte mask (0001/0011/1111)
- lsu_func3  in  3  load type (lb/lh/lw/lbu/lhu)
- lsu_resp_valid  out  1  load data / store ack (one-cycle pulse)
- lsu_rdata  out  DATA_W  load data, already extended by memory
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_wen, mem_addr, mem_wdata, mem_wmask, mem_func3  out  1/ADDR_W/DATA_W/4/3  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state IDLE.
- IDLE: if any req_valid, grant per arbitration; assert winner's req_ready combinationally; latch fields into request register; owner <= winner; go REQ. Loser's ready stays 0.
- Arbitration: single request wins outright. Both valid: winner is the one not in last_grant. last_grant updated on every grant; reset value LSU (so IFU wins first tie).
- IFU request fields: wen=0, wmask=4'b0000, func3=3'b010, wdata=0.
- REQ: mem_req_valid=1, fields stable from register. On mem_req_ready: go WAIT; if mem_resp_valid also high that cycle, complete directly (see WAIT exit) and go IDLE.
- WAIT: on mem_resp_valid, pulse owner's resp_valid for that cycle, route mem_rdata to owner's rdata, go IDLE. Stores also receive resp_valid (ack); rdata don't-care.
- mem_resp_valid outside REQ/WAIT is ignored.
- Non-owner resp_valid always 0; *_rdata driven from mem_rdata unconditionally (qualified by resp_valid).

## Timing
- Reset outputs: all ready/valid outputs 0, mem_* fields 0, state IDLE, owner IFU, last_grant LSU.
- Accept in cycle N (valid & ready) -> mem_req_valid high from N+1, held until mem_req_ready sampled high.
- Minimum latency accept -> resp_valid: 1 cycle (ready and resp in N+1). Response pass-through is combinational.
- Back-to-back: new request can be accepted the cycle after resp_valid (IDLE); no accept in the response cycle.
- rst asserted mid-transaction: abort immediately, drop owner and latched request; late mem_resp_valid after reset is ignored (state IDLE).
- Requesters must hold valid and fields until ready; arbiter does not require it after accept.

## Structure
- Shared package ysyx_25050148_pkg: state enum (IDLE/REQ/WAIT), requester id constants (IFU=0, LSU=1), IFU default func3 constant 3'b010.
- Single module, no sub-modules; request register and round-robin pointer inline.

## Test plan
- IFU only, addr 0x8000_0000, memory ready+resp in next cycle -> ifu_req_ready at N, mem_req_valid N+1, ifu_resp_valid at N+1 with mem data 0x0000_0413; lsu_resp_valid stays 0.
- Both valid from reset -> IFU granted first; LSU granted in the next IDLE; then both again -> IFU (alternation, no starvation over 10 rounds).
- LSU store addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 1111; mem_req_ready delayed 3 cycles -> mem fields stable for 3 cycles, single lsu_resp_valid pulse on ack.
- LSU lb func3 000, mem_resp_valid delayed 5 cycles in WAIT -> no resp before; lsu_resp_valid one cycle with rdata 0xFFFF_FF80.
- rst pulse while in WAIT, then stray mem_resp_valid -> all outputs 0, no resp_valid pulse, next IFU request served normally.
- Spurious mem_resp_valid in IDLE -> ignored, no resp_valid to either requester.

Source files
------------

// File: rtl/ysyx_25050148_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25050148_mem_arbiter_pkg
// Shared definitions for the IFU/LSU memory-port arbiter:
//   state_t      - arbiter FSM states (IDLE / REQ / WAIT)
//   ID_IFU/ID_LSU - requester identifiers used for owner and last-grant
//   IFU_FUNC3    - access type forced onto instruction fetches (word load)
//   rr_pick_lsu  - round-robin decision helper
// ----------------------------------------------------------------------------
package ysyx_25050148_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic       ID_IFU    = 1'b0;
   localparam logic       ID_LSU    = 1'b1;
   localparam logic [2:0] IFU_FUNC3 = 3'b010;

   // A lone requester wins outright; on a tie the requester that did not
   // win last time is chosen, so neither side can be starved.
   function automatic logic rr_pick_lsu(input logic i_ifu_valid,
                                        input logic i_lsu_valid,
                                        input logic i_last_grant);
      return i_lsu_valid & (~i_ifu_valid | (i_last_grant == ID_IFU));
   endfunction

endpackage

// File: rtl/ysyx_25050148_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_25050148_mem_arbiter_if
// Bundles the three channels around the arbiter:
//   ifu_*  - instruction-fetch request / response
//   lsu_*  - load/store request / response
//   mem_*  - shared physical-memory request / response
// Modports:
//   slave  - the arbiter's view (takes requests, drives memory request)
//   master - the environment's view (requesters plus memory model)
// ----------------------------------------------------------------------------
interface ysyx_25050148_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_resp_valid;
   logic [DATA_W-1:0] ifu_rdata;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic              lsu_wen;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic [3:0]        lsu_wmask;
   logic [2:0]        lsu_func3;
   logic              lsu_resp_valid;
   logic [DATA_W-1:0] lsu_rdata;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_wmask;
   logic [2:0]        mem_func3;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_func3,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_func3,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_func3,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_func3,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface

// File: rtl/ysyx_25050148_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25050148_mem_arbiter
// Shares the single memory port between IFU and LSU. One transaction is in
// flight at a time: IDLE grants a requester (round robin on ties) and latches
// its fields, REQ presents them until memory accepts, WAIT holds until the
// response arrives, which is passed straight through to the owner.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave modport carrying the IFU, LSU and memory channels
// ----------------------------------------------------------------------------
module ysyx_25050148_mem_arbiter
   import ysyx_25050148_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   ysyx_25050148_mem_arbiter_if.slave    bus
);

   state_t            r_state;
   logic              r_owner;
   logic              r_last_grant;
   logic              r_mem_req_valid;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wmask;
   logic [2:0]        r_func3;

   logic              w_pick_lsu;
   logic              w_ifu_ready;
   logic              w_lsu_ready;
   logic              w_resp_done;
   logic              w_accept;

   // Grant decision in IDLE and response detection in REQ/WAIT; a response
   // arriving together with mem_req_ready completes the transaction at once.
   always_comb begin
      w_pick_lsu  = 1'b0;
      w_ifu_ready = 1'b0;
      w_lsu_ready = 1'b0;
      w_resp_done = 1'b0;
      case (r_state)
         IDLE: begin
            w_pick_lsu  = rr_pick_lsu(bus.ifu_req_valid, bus.lsu_req_valid, r_last_grant);
            w_lsu_ready = w_pick_lsu;
            w_ifu_ready = bus.ifu_req_valid & ~w_pick_lsu;
         end
         REQ:     w_resp_done = bus.mem_req_ready & bus.mem_resp_valid;
         WAIT:    w_resp_done = bus.mem_resp_valid;
         default: w_resp_done = 1'b0;
      endcase
   end

   assign w_accept = w_ifu_ready | w_lsu_ready;

   assign bus.ifu_req_ready  = w_ifu_ready;
   assign bus.lsu_req_ready  = w_lsu_ready;
   assign bus.ifu_resp_valid = w_resp_done & (r_owner == ID_IFU);
   assign bus.lsu_resp_valid = w_resp_done & (r_owner == ID_LSU);
   assign bus.ifu_rdata      = bus.mem_rdata;
   assign bus.lsu_rdata      = bus.mem_rdata;

   assign bus.mem_req_valid  = r_mem_req_valid;
   assign bus.mem_wen        = r_wen;
   assign bus.mem_addr       = r_addr;
   assign bus.mem_wdata      = r_wdata;
   assign bus.mem_wmask      = r_wmask;
   assign bus.mem_func3      = r_func3;

   // Arbiter FSM with the latched request register and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_owner         <= ID_IFU;
         r_last_grant    <= ID_LSU;
         r_mem_req_valid <= 1'b0;
         r_wen           <= 1'b0;
         r_addr          <= {ADDR_W{1'b0}};
         r_wdata         <= {DATA_W{1'b0}};
         r_wmask         <= 4'b0000;
         r_func3         <= 3'b000;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_owner         <= w_pick_lsu ? ID_LSU : ID_IFU;
                  r_last_grant    <= w_pick_lsu ? ID_LSU : ID_IFU;
                  r_mem_req_valid <= 1'b1;
                  r_state         <= REQ;
                  if (w_pick_lsu) begin
                     r_wen   <= bus.lsu_wen;
                     r_addr  <= bus.lsu_addr;
                     r_wdata <= bus.lsu_wdata;
                     r_wmask <= bus.lsu_wmask;
                     r_func3 <= bus.lsu_func3;
                  end else begin
                     // Fetches are always plain word loads.
                     r_wen   <= 1'b0;
                     r_addr  <= bus.ifu_addr;
                     r_wdata <= {DATA_W{1'b0}};
                     r_wmask <= 4'b0000;
                     r_func3 <= IFU_FUNC3;
                  end
               end
            end
            REQ: begin
               if (bus.mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= bus.mem_resp_valid ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_resp_valid) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state         <= IDLE;
               r_mem_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25050148_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25050148_mem_arbiter
// Directed self-checking bench for the IFU/LSU memory arbiter. Inputs change
// 1 time unit after each rising edge, outputs are checked 1 unit later.
// ----------------------------------------------------------------------------
module tb_ysyx_25050148_mem_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic exp_ifu;

   ysyx_25050148_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ysyx_25050148_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.ifu_req_valid = 1'b0;
      bus.ifu_addr      = 32'h0000_0000;
      bus.lsu_req_valid = 1'b0;
      bus.lsu_wen       = 1'b0;
      bus.lsu_addr      = 32'h0000_0000;
      bus.lsu_wdata     = 32'h0000_0000;
      bus.lsu_wmask     = 4'b0000;
      bus.lsu_func3     = 3'b000;
      bus.mem_rdata     = 32'h0000_0000;
      clear_mem();

      // ---- reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_ctrl", {24'd0, bus.mem_wen, bus.mem_wmask, bus.mem_func3}, 32'd0);
      chk("rst_resp", {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 32'd0);
      rst = 1'b0;
      tick();

      // ---- IFU only, memory ready + response in the next cycle
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = 32'h8000_0000;
      #1;
      chk("t1_ifu_ready", {31'd0, bus.ifu_req_ready}, 32'd1);
      chk("t1_lsu_ready", {31'd0, bus.lsu_req_ready}, 32'd0);
      chk("t1_mreq_before", {31'd0, bus.mem_req_valid}, 32'd0);
      tick();
      bus.ifu_addr       = 32'h8000_0004;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h0000_0413;
      #1;
      chk("t1_mreq_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      chk("t1_mem_addr", bus.mem_addr, 32'h8000_0000);
      chk("t1_mem_ctrl", {24'd0, bus.mem_wen, bus.mem_wmask, bus.mem_func3}, 32'h0000_0002);
      chk("t1_ifu_resp", {31'd0, bus.ifu_resp_valid}, 32'd1);
      chk("t1_ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
      chk("t1_lsu_resp", {31'd0, bus.lsu_resp_valid}, 32'd0);
      chk("t1_no_accept_in_resp", {31'd0, bus.ifu_req_ready}, 32'd0);
      tick();
      bus.ifu_req_valid = 1'b0;
      clear_mem();
      #1;
      chk("t1_idle_after", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("t1_resp_cleared", {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 32'd0);

      // ---- both valid from reset: IFU first, then strict alternation
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.ifu_addr  = 32'h8000_0004;
      bus.lsu_wen   = 1'b0;
      bus.lsu_addr  = 32'h0000_0100;
      bus.lsu_func3 = 3'b010;
      exp_ifu = 1'b1;
      for (int r = 0; r < 10; r++) begin
         bus.ifu_req_valid = 1'b1;
         bus.lsu_req_valid = 1'b1;
         #1;
         chk("rr_ifu_ready", {31'd0, bus.ifu_req_ready}, {31'd0, exp_ifu});
         chk("rr_lsu_ready", {31'd0, bus.lsu_req_ready}, {31'd0, ~exp_ifu});
         tick();
         bus.mem_req_ready  = 1'b1;
         bus.mem_resp_valid = 1'b1;
         bus.mem_rdata      = 32'(r);
         #1;
         chk("rr_mem_addr", bus.mem_addr, exp_ifu ? 32'h8000_0004 : 32'h0000_0100);
         chk("rr_ifu_resp", {31'd0, bus.ifu_resp_valid}, {31'd0, exp_ifu});
         chk("rr_lsu_resp", {31'd0, bus.lsu_resp_valid}, {31'd0, ~exp_ifu});
         tick();
         clear_mem();
         exp_ifu = ~exp_ifu;
      end
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      tick();

      // ---- LSU store, mem_req_ready held off for 3 cycles
      bus.lsu_req_valid = 1'b1;
      bus.lsu_wen       = 1'b1;
      bus.lsu_addr      = 32'h8000_1000;
      bus.lsu_wdata     = 32'hDEAD_BEEF;
      bus.lsu_wmask     = 4'b1111;
      bus.lsu_func3     = 3'b010;
      #1;
      chk("st_lsu_ready", {31'd0, bus.lsu_req_ready}, 32'd1);
      tick();
      bus.lsu_req_valid = 1'b0;
      bus.lsu_wdata     = 32'h0000_0000;
      bus.lsu_addr      = 32'h0000_0000;
      bus.lsu_wmask     = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("st_mreq_valid", {31'd0, bus.mem_req_valid}, 32'd1);
         chk("st_mem_addr", bus.mem_addr, 32'h8000_1000);
         chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
         chk("st_mem_ctrl", {24'd0, bus.mem_wen, bus.mem_wmask, bus.mem_func3}, 32'h0000_00FA);
         chk("st_no_resp", {31'd0, bus.lsu_resp_valid}, 32'd0);
         tick();
      end
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      #1;
      chk("st_ack", {31'd0, bus.lsu_resp_valid}, 32'd1);
      chk("st_ifu_quiet", {31'd0, bus.ifu_resp_valid}, 32'd0);
      tick();
      clear_mem();
      bus.lsu_wen = 1'b0;
      #1;
      chk("st_single_pulse", {31'd0, bus.lsu_resp_valid}, 32'd0);

      // ---- LSU lb, response delayed 5 cycles in WAIT
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_1003;
      bus.lsu_func3     = 3'b000;
      #1;
      chk("lb_lsu_ready", {31'd0, bus.lsu_req_ready}, 32'd1);
      tick();
      bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      #1;
      chk("lb_mem_func3", {29'd0, bus.mem_func3}, 32'd0);
      chk("lb_mem_addr", bus.mem_addr, 32'h8000_1003);
      chk("lb_no_resp_req", {31'd0, bus.lsu_resp_valid}, 32'd0);
      tick();
      bus.mem_req_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("lb_wait_mreq", {31'd0, bus.mem_req_valid}, 32'd0);
         chk("lb_wait_no_resp", {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 32'd0);
         tick();
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'hFFFF_FF80;
      #1;
      chk("lb_resp", {31'd0, bus.lsu_resp_valid}, 32'd1);
      chk("lb_rdata", bus.lsu_rdata, 32'hFFFF_FF80);
      tick();
      clear_mem();
      #1;
      chk("lb_single_pulse", {31'd0, bus.lsu_resp_valid}, 32'd0);

      // ---- reset while in WAIT, then a stray response
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = 32'h8000_0010;
      tick();
      bus.ifu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rw_mreq", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("rw_mem_addr", bus.mem_addr, 32'd0);
      chk("rw_mem_ctrl", {24'd0, bus.mem_wen, bus.mem_wmask, bus.mem_func3}, 32'd0);
      tick();
      rst = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h1234_5678;
      #1;
      chk("rw_stray_resp", {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 32'd0);
      tick();
      clear_mem();
      bus.ifu_req_valid = 1'b1;
      #1;
      chk("rw_ifu_ready", {31'd0, bus.ifu_req_ready}, 32'd1);
      tick();
      bus.ifu_req_valid  = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h0000_0093;
      #1;
      chk("rw_mem_addr_new", bus.mem_addr, 32'h8000_0010);
      chk("rw_ifu_resp", {31'd0, bus.ifu_resp_valid}, 32'd1);
      chk("rw_ifu_rdata", bus.ifu_rdata, 32'h0000_0093);
      tick();
      clear_mem();

      // ---- spurious response while IDLE
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'hCAFE_F00D;
      #1;
      chk("idle_spurious_resp", {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 32'd0);
      chk("idle_spurious_mreq", {31'd0, bus.mem_req_valid}, 32'd0);
      tick();
      clear_mem();
      #1;
      chk("idle_still_idle", {31'd0, bus.mem_req_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
